// File: rtl/cpu_step_controller.sv
// cpu_step_controller
// Generates the CPU clock for the multi-cycle CPU. Three modes are supported:
// single-step from a debounced push button, free-run at a divided rate, and
// halt when the CPU PC matches a breakpoint address.
//
// Ports:
//   clk          board clock, every flop is on its rising edge
//   Reset        asynchronous active-high reset
//   button       raw push button (asynchronous, bouncy)
//   run_sw       1 = free-run, 0 = single-step
//   bp_en        breakpoint enable
//   bp_addr[7:0] breakpoint PC
//   cur_pc[7:0]  current CPU PC
//   cpu_clk      registered CPU clock, high exactly in S_HI / R_HI
//   status[2:0]  000 idle, 001 stepping, 010 running, 011 halted
//   halted       high only in HALT
//   cycle_count  ticks issued since reset, wraps at 16 bits
module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HALF            = 25000000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        button,
    input  logic        run_sw,
    input  logic        bp_en,
    input  logic [7:0]  bp_addr,
    input  logic [7:0]  cur_pc,
    output logic        cpu_clk,
    output logic [2:0]  status,
    output logic        halted,
    output logic [15:0] cycle_count
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PH_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S_HI = 3'd1,
        ST_S_LO = 3'd2,
        ST_R_HI = 3'd3,
        ST_R_LO = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    logic            sync1_q, sync2_q;
    logic            btn_db_q, btn_db_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q, press_d;
    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [15:0]     cycle_count_q, cycle_count_d;
    logic            cpu_clk_q, cpu_clk_d;
    logic [2:0]      status_q, status_d;
    logic            halted_q, halted_d;
    logic            phase_end_s;
    logic            bp_hit_s;

    // Debounce: accept the synchronized level only after it has differed from
    // the accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = {DB_W{1'b0}};
        if (sync2_q == btn_db_q) begin
            db_cnt_d = {DB_W{1'b0}};
        end else if (db_cnt_q == DB_LAST) begin
            btn_db_d = sync2_q;
            db_cnt_d = {DB_W{1'b0}};
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
        // Pulse registered in the same edge that raises btn_db
        press_d = btn_db_d & ~btn_db_q;
    end

    // Tick sequencer: next state, phase counter and tick counter.
    always_comb begin
        phase_end_s   = (phase_q == PH_LAST);
        bp_hit_s      = bp_en && (cur_pc == bp_addr);
        state_d       = state_q;
        phase_d       = phase_q + PH_W'(1);
        cycle_count_d = cycle_count_q;
        case (state_q)
            ST_IDLE: begin
                phase_d = {PH_W{1'b0}};
                if (run_sw) begin
                    state_d       = ST_R_HI;
                    cycle_count_d = cycle_count_q + 16'd1;
                end else if (press_q) begin
                    state_d       = ST_S_HI;
                    cycle_count_d = cycle_count_q + 16'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_S_HI: begin
                if (phase_end_s) begin
                    state_d = ST_S_LO;
                    phase_d = {PH_W{1'b0}};
                end else begin
                    state_d = ST_S_HI;
                end
            end
            ST_S_LO: begin
                if (phase_end_s) begin
                    state_d = ST_IDLE;
                    phase_d = {PH_W{1'b0}};
                end else begin
                    state_d = ST_S_LO;
                end
            end
            ST_R_HI: begin
                if (phase_end_s) begin
                    state_d = ST_R_LO;
                    phase_d = {PH_W{1'b0}};
                end else begin
                    state_d = ST_R_HI;
                end
            end
            ST_R_LO: begin
                // Mode and breakpoint are only looked at on the tick boundary,
                // after the CPU has already seen the rising edge.
                if (phase_end_s) begin
                    phase_d = {PH_W{1'b0}};
                    if (bp_hit_s) begin
                        state_d = ST_HALT;
                    end else if (!run_sw) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d       = ST_R_HI;
                        cycle_count_d = cycle_count_q + 16'd1;
                    end
                end else begin
                    state_d = ST_R_LO;
                end
            end
            ST_HALT: begin
                phase_d = {PH_W{1'b0}};
                if (!run_sw) begin
                    state_d = ST_IDLE;
                end else if (press_q) begin
                    state_d       = ST_R_HI;
                    cycle_count_d = cycle_count_q + 16'd1;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = {PH_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up
    // with the state register.
    always_comb begin
        cpu_clk_d = (state_d == ST_S_HI) || (state_d == ST_R_HI);
        halted_d  = (state_d == ST_HALT);
        case (state_d)
            ST_S_HI, ST_S_LO: status_d = 3'b001;
            ST_R_HI, ST_R_LO: status_d = 3'b010;
            ST_HALT:          status_d = 3'b011;
            default:          status_d = 3'b000;
        endcase
    end

    // Button synchronizer and debounce registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt_q <= {DB_W{1'b0}};
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= button;
            sync2_q  <= sync1_q;
            btn_db_q <= btn_db_d;
            db_cnt_q <= db_cnt_d;
            press_q  <= press_d;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            phase_q       <= {PH_W{1'b0}};
            cycle_count_q <= 16'd0;
            cpu_clk_q     <= 1'b0;
            status_q      <= 3'b000;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            cycle_count_q <= cycle_count_d;
            cpu_clk_q     <= cpu_clk_d;
            status_q      <= status_d;
            halted_q      <= halted_d;
        end
    end

    assign cpu_clk     = cpu_clk_q;
    assign status      = status_q;
    assign halted      = halted_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: directed scenarios with randomized tick
// counts, drop points, bounce patterns and breakpoint addresses. Expected
// waveforms come from the tick arithmetic (period 2*HALF, high HALF).
`timescale 1ns/100ps
module tb_cpu_step_controller;

    localparam int DB   = 4;
    localparam int HALF = 3;
    localparam int PER  = 2 * HALF;

    logic        clk = 1'b0, clk_en = 1'b0;
    logic        clk_w = 1'b0, clk_w_en = 1'b0;
    logic        rst = 1'b0, rst_w = 1'b0;
    logic        button = 1'b0, run_sw = 1'b0, run_sw_w = 1'b0;
    logic        bp_en = 1'b0;
    logic [7:0]  bp_addr = 8'h00;
    logic [7:0]  cur_pc;
    logic        cpu_clk, halted, cpu_clk_w, halted_w;
    logic [2:0]  status, status_w;
    logic [15:0] cycle_count, cycle_count_w;
    logic [15:0] exp_count = 16'd0;
    int          n_cmp = 0, n_bad = 0;

    cpu_step_controller #(.DEBOUNCE_CYCLES(DB), .HALF(HALF)) dut (
        .clk(clk), .Reset(rst), .button(button), .run_sw(run_sw),
        .bp_en(bp_en), .bp_addr(bp_addr), .cur_pc(cur_pc),
        .cpu_clk(cpu_clk), .status(status), .halted(halted),
        .cycle_count(cycle_count)
    );

    cpu_step_controller #(.DEBOUNCE_CYCLES(DB), .HALF(1)) dut_w (
        .clk(clk_w), .Reset(rst_w), .button(1'b0), .run_sw(run_sw_w),
        .bp_en(1'b0), .bp_addr(8'h00), .cur_pc(8'h00),
        .cpu_clk(cpu_clk_w), .status(status_w), .halted(halted_w),
        .cycle_count(cycle_count_w)
    );

    always #5 if (clk_en) clk = ~clk;
    always #1 if (clk_w_en) clk_w = ~clk_w;

    // Behavioural CPU: PC advances by 4 on each CPU clock rise
    always @(posedge cpu_clk or posedge rst) begin
        if (rst) cur_pc <= 8'h00;
        else     cur_pc <= cur_pc + 8'd4;
    end

    task automatic do_reset();
        @(negedge clk);
        run_sw = 1'b0; button = 1'b0; bp_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; exp_count = 16'd0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (cpu_clk !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_clk: got %0h expected 0", cpu_clk); end
        n_cmp++; if (status !== 3'b000) begin n_bad++; $display("FAIL reset_status: got %0h expected 0", status); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %0h expected 0", halted); end
        n_cmp++; if (cycle_count !== 16'h0000) begin n_bad++; $display("FAIL reset_count: got %0h expected 0", cycle_count); end
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (status !== 3'b000) begin n_bad++; $display("FAIL reset_idle: got %0h expected 0", status); end
    endtask

    task automatic test_debounce();
        int t, k, hi, r;
        logic       exp_c;
        logic [2:0] exp_s;
        // bounce: no level survives DB cycles
        t = 0; hi = 0;
        while (t < 20) begin
            k = $urandom_range(1, DB - 1);
            button = ~button;
            for (int j = 0; j < k; j++) begin
                @(negedge clk);
                if (cpu_clk === 1'b1) hi++;
            end
            t += k;
        end
        button = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (cpu_clk === 1'b1) hi++;
        end
        n_cmp++; if (hi !== 0) begin n_bad++; $display("FAIL bounce_high: got %0d expected 0", hi); end
        n_cmp++; if (cycle_count !== exp_count) begin n_bad++; $display("FAIL bounce_count: got %0h expected %0h", cycle_count, exp_count); end
        // clean press held high
        button = 1'b1; r = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (r == 0 && cpu_clk === 1'b1) r = i;
            if (r != 0) begin
                exp_c = (i < r + HALF);
                exp_s = (i < r + PER) ? 3'b001 : 3'b000;
                n_cmp++; if (cpu_clk !== exp_c) begin n_bad++; $display("FAIL step_clk[%0d]: got %0h expected %0h", i, cpu_clk, exp_c); end
                n_cmp++; if (status !== exp_s) begin n_bad++; $display("FAIL step_status[%0d]: got %0h expected %0h", i, status, exp_s); end
            end else begin
                n_cmp++; if (status !== 3'b000) begin n_bad++; $display("FAIL pre_step_status[%0d]: got %0h expected 0", i, status); end
            end
        end
        n_cmp++; if (r < 2 + DB || r > 4 + DB) begin n_bad++; $display("FAIL press_latency: got %0d expected %0d+-1", r, 3 + DB); end
        exp_count = exp_count + 16'd1;
        n_cmp++; if (cycle_count !== exp_count) begin n_bad++; $display("FAIL step_count1: got %0h expected %0h", cycle_count, exp_count); end
        // second press after a clean release
        hi = 0;
        for (int i = 0; i < 44; i++) begin
            button = (i >= 12 && i < 32);
            @(negedge clk);
            if (cpu_clk === 1'b1) hi++;
        end
        exp_count = exp_count + 16'd1;
        n_cmp++; if (hi !== HALF) begin n_bad++; $display("FAIL step2_high: got %0d expected %0d", hi, HALF); end
        n_cmp++; if (cycle_count !== exp_count) begin n_bad++; $display("FAIL step_count2: got %0h expected %0h", cycle_count, exp_count); end
    endtask

    task automatic test_run();
        int n, d, last;
        bit active;
        logic       exp_c;
        logic [2:0] exp_s;
        logic [15:0] c0, exp_cc;
        n = $urandom_range(3, 6);
        d = $urandom_range(0, PER - 1);
        c0 = exp_count;
        bp_en = 1'b0;
        bp_addr = 8'($urandom_range(0, 63) * 4);
        last = 1 + PER * (n - 1);
        run_sw = 1'b1;
        for (int i = 1; i <= PER * n + 12; i++) begin
            @(negedge clk);
            active = (i <= PER * n);
            exp_c  = active && (((i - 1) % PER) < HALF);
            exp_s  = active ? 3'b010 : 3'b000;
            exp_cc = c0 + 16'(active ? ((i - 1) / PER + 1) : n);
            n_cmp++; if (cpu_clk !== exp_c) begin n_bad++; $display("FAIL run_clk[%0d]: got %0h expected %0h", i, cpu_clk, exp_c); end
            n_cmp++; if (status !== exp_s) begin n_bad++; $display("FAIL run_status[%0d]: got %0h expected %0h", i, status, exp_s); end
            n_cmp++; if (cycle_count !== exp_cc) begin n_bad++; $display("FAIL run_count[%0d]: got %0h expected %0h", i, cycle_count, exp_cc); end
            if (i == last + d) run_sw = 1'b0;
        end
        exp_count = c0 + 16'(n);
    endtask

    task automatic test_breakpoint(input bit drop_run);
        int k, d, r;
        bit active;
        logic       exp_c, exp_h;
        logic [2:0] exp_s;
        logic [15:0] exp_cc;
        do_reset();
        k = $urandom_range(1, drop_run ? 3 : 5);
        d = $urandom_range(0, PER - 1);
        bp_en = 1'b1; bp_addr = 8'(4 * k); run_sw = 1'b1;
        for (int i = 1; i <= PER * k + 6; i++) begin
            @(negedge clk);
            active = (i <= PER * k);
            exp_c  = active && (((i - 1) % PER) < HALF);
            if (active) exp_s = 3'b010;
            else if (drop_run && i > PER * k + 1) exp_s = 3'b000;
            else exp_s = 3'b011;
            exp_h  = (exp_s == 3'b011);
            exp_cc = 16'(active ? ((i - 1) / PER + 1) : k);
            n_cmp++; if (cpu_clk !== exp_c) begin n_bad++; $display("FAIL bp_clk[%0d]: got %0h expected %0h", i, cpu_clk, exp_c); end
            n_cmp++; if (status !== exp_s) begin n_bad++; $display("FAIL bp_status[%0d]: got %0h expected %0h", i, status, exp_s); end
            n_cmp++; if (halted !== exp_h) begin n_bad++; $display("FAIL bp_halted[%0d]: got %0h expected %0h", i, halted, exp_h); end
            n_cmp++; if (cycle_count !== exp_cc) begin n_bad++; $display("FAIL bp_count[%0d]: got %0h expected %0h", i, cycle_count, exp_cc); end
            if (drop_run && i == 1 + PER * (k - 1) + d) run_sw = 1'b0;
        end
        n_cmp++; if (cur_pc !== 8'(4 * k)) begin n_bad++; $display("FAIL bp_pc: got %0h expected %0h", cur_pc, 8'(4 * k)); end
        exp_count = 16'(k);
        if (!drop_run) begin
            // resume from HALT with a press, then finish with one tick
            button = 1'b1; r = 0;
            for (int i = 1; i <= 30; i++) begin
                @(negedge clk);
                if (i == 10) button = 1'b0;
                if (r == 0 && cpu_clk === 1'b1) begin
                    r = i;
                end else if (r == 0) begin
                    n_cmp++; if (status !== 3'b011) begin n_bad++; $display("FAIL halt_hold[%0d]: got %0h expected 3", i, status); end
                end else begin
                    if (i == r + 2) run_sw = 1'b0;
                    if (i >= r + PER) begin
                        n_cmp++; if (status !== 3'b000 || cpu_clk !== 1'b0) begin n_bad++; $display("FAIL resume_end[%0d]: got %0h/%0h expected 0/0", i, status, cpu_clk); end
                    end
                end
            end
            exp_count = 16'(k + 1);
            n_cmp++; if (r < 2 + DB || r > 4 + DB) begin n_bad++; $display("FAIL resume_latency: got %0d expected %0d+-1", r, 3 + DB); end
            n_cmp++; if (cycle_count !== exp_count) begin n_bad++; $display("FAIL resume_count: got %0h expected %0h", cycle_count, exp_count); end
            n_cmp++; if (cur_pc !== 8'(4 * k + 4)) begin n_bad++; $display("FAIL resume_pc: got %0h expected %0h", cur_pc, 8'(4 * k + 4)); end
        end
        bp_en = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        run_sw = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (cpu_clk !== 1'b1) begin n_bad++; $display("FAIL ar_pre_clk: got %0h expected 1", cpu_clk); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (cpu_clk !== 1'b0) begin n_bad++; $display("FAIL ar_clk: got %0h expected 0", cpu_clk); end
        n_cmp++; if (status !== 3'b000) begin n_bad++; $display("FAIL ar_status: got %0h expected 0", status); end
        n_cmp++; if (cycle_count !== 16'h0000) begin n_bad++; $display("FAIL ar_count: got %0h expected 0", cycle_count); end
        @(negedge clk);
        n_cmp++; if (cpu_clk !== 1'b0) begin n_bad++; $display("FAIL ar_held: got %0h expected 0", cpu_clk); end
        rst = 1'b0;
        @(negedge clk);
        exp_count = 16'd1;
        n_cmp++; if (cpu_clk !== 1'b1) begin n_bad++; $display("FAIL ar_restart_clk: got %0h expected 1", cpu_clk); end
        n_cmp++; if (cycle_count !== exp_count) begin n_bad++; $display("FAIL ar_restart_count: got %0h expected %0h", cycle_count, exp_count); end
        n_cmp++; if (status !== 3'b010) begin n_bad++; $display("FAIL ar_restart_status: got %0h expected 2", status); end
        run_sw = 1'b0;
        repeat (PER + 2) @(negedge clk);
        n_cmp++; if (status !== 3'b000) begin n_bad++; $display("FAIL ar_idle: got %0h expected 0", status); end
    endtask

    task automatic test_wrap();
        int  rises;
        bit  done;
        logic prev;
        rises = 0; done = 1'b0; prev = 1'b0;
        clk_en = 1'b0; clk_w_en = 1'b1; rst_w = 1'b1; run_sw_w = 1'b0;
        repeat (2) @(negedge clk_w);
        n_cmp++; if (cycle_count_w !== 16'h0000) begin n_bad++; $display("FAIL wrap_reset: got %0h expected 0", cycle_count_w); end
        rst_w = 1'b0; run_sw_w = 1'b1;
        for (int i = 0; i < 140000 && !done; i++) begin
            @(negedge clk_w);
            if (cpu_clk_w === 1'b1 && prev === 1'b0) begin
                rises++;
                n_cmp++;
                if (cycle_count_w !== 16'(rises)) begin
                    n_bad++; done = 1'b1;
                    $display("FAIL wrap_count[%0d]: got %0h expected %0h", rises, cycle_count_w, 16'(rises));
                end
                if (rises == 65536) done = 1'b1;
            end
            prev = cpu_clk_w;
        end
        n_cmp++; if (rises != 65536) begin n_bad++; $display("FAIL wrap_ticks: got %0d expected 65536", rises); end
        n_cmp++; if (cycle_count_w !== 16'h0000) begin n_bad++; $display("FAIL wrap_final: got %0h expected 0", cycle_count_w); end
        n_cmp++; if (status_w !== 3'b010 || halted_w !== 1'b0) begin n_bad++; $display("FAIL wrap_status: got %0h/%0h expected 2/0", status_w, halted_w); end
        clk_w_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_run();
        test_breakpoint(1'b0);
        test_breakpoint(1'b1);
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
